// File: rtl/event_encoder_8x3_pkg.sv
// Shared widths, types and bit-index helpers for the 8-line event encoder.
package event_encoder_8x3_pkg;

  localparam int N_IN   = 8;
  localparam int CODE_W = $clog2(N_IN);

  typedef logic [N_IN-1:0]   req_t;
  typedef logic [CODE_W-1:0] code_t;

  // Bit 0 wins: scan from the top so the lowest set bit is the last one written.
  function automatic code_t lowest_set_idx(input req_t v);
    code_t idx;
    idx = '0;
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (v[i]) idx = code_t'(i);
    end
    return idx;
  endfunction

  function automatic req_t onehot(input code_t idx);
    return req_t'(1) << idx;
  endfunction

endpackage

// File: rtl/event_encoder_8x3_lsb_priority_encoder.sv
// Combinational 8->3 priority encoder; the lowest set request bit has priority.
module lsb_priority_encoder
  import event_encoder_8x3_pkg::*;
(
  input  logic [N_IN-1:0]   req,
  output logic [CODE_W-1:0] idx,
  output logic              any
);

  assign idx = lowest_set_idx(req);
  assign any = |req;

endmodule

// File: rtl/event_encoder_8x3.sv
// Captures events on 8 request lines as pending bits and issues one binary
// code per event over a valid/ready handshake, lowest index first.
module event_encoder_8x3
  import event_encoder_8x3_pkg::*;
#(
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_IN-1:0]   in,
  input  logic              clr,
  output logic [CODE_W-1:0] out,
  output logic              valid,
  input  logic              ready,
  output logic [N_IN-1:0]   pending,
  output logic              overflow
);

  logic [N_IN-1:0]   in_d;
  logic [N_IN-1:0]   ev;
  logic [CODE_W-1:0] sel;
  logic              pending_any;
  logic              load;
  logic [N_IN-1:0]   load_mask;
  logic [N_IN-1:0]   pending_next;
  logic              overflow_next;

  lsb_priority_encoder u_prio (
    .req (pending),
    .idx (sel),
    .any (pending_any)
  );

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    ev            = '0;
    load          = 1'b0;
    load_mask     = '0;
    pending_next  = pending;
    overflow_next = 1'b0;

    ev   = EDGE_MODE ? (in & ~in_d) : in;
    load = (!valid || ready) && pending_any;
    if (load) load_mask = onehot(sel);

    // A new event on the bit being loaded this cycle is kept, not flagged.
    pending_next  = (pending & ~load_mask) | ev;
    overflow_next = EDGE_MODE && (|(ev & pending & ~load_mask));
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_d     <= '0;
      pending  <= '0;
      out      <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      in_d <= in;
      if (clr) begin
        pending  <= '0;
        valid    <= 1'b0;
        overflow <= 1'b0;
      end else begin
        pending  <= pending_next;
        overflow <= overflow_next;
        if (load) begin
          out   <= sel;
          valid <= 1'b1;
        end else if (valid && ready) begin
          valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_event_encoder_8x3.sv
// Directed and randomized bench for event_encoder_8x3 against a cycle model.
module tb_event_encoder_8x3;

  localparam bit EDGE = 1'b1;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_lines;
  logic       clr;
  logic [2:0] out;
  logic       valid;
  logic       ready;
  logic [7:0] pending;
  logic       overflow;

  int n_total = 0;
  int n_pass  = 0;

  // Reference state, kept as plain bits and ints.
  bit m_in_d [8];
  bit m_pend [8];
  int m_out;
  bit m_valid;
  bit m_ovf;

  event_encoder_8x3 #(.EDGE_MODE(EDGE)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (in_lines),
    .clr      (clr),
    .out      (out),
    .valid    (valid),
    .ready    (ready),
    .pending  (pending),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int pend_value();
    int v = 0;
    for (int i = 0; i < 8; i++) if (m_pend[i]) v += (1 << i);
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_in_d[i] = 1'b0;
      m_pend[i] = 1'b0;
    end
    m_out   = 0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
  endtask

  task automatic model_edge();
    bit ev [8];
    int sel;
    for (int i = 0; i < 8; i++) begin
      ev[i]     = EDGE ? (in_lines[i] && !m_in_d[i]) : in_lines[i];
      m_in_d[i] = in_lines[i];
    end
    if (clr) begin
      for (int i = 0; i < 8; i++) m_pend[i] = 1'b0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
    end else begin
      sel = -1;
      if (!m_valid || ready) begin
        for (int i = 0; i < 8; i++) begin
          if (m_pend[i] && sel < 0) sel = i;
        end
      end
      m_ovf = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (EDGE && ev[i] && m_pend[i] && i != sel) m_ovf = 1'b1;
      end
      if (sel >= 0) begin
        m_pend[sel] = 1'b0;
        m_out       = sel;
        m_valid     = 1'b1;
      end else if (m_valid && ready) begin
        m_valid = 1'b0;
      end
      for (int i = 0; i < 8; i++) if (ev[i]) m_pend[i] = 1'b1;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".out"},      32'(out),      32'(m_out));
    check({tag, ".valid"},    32'(valid),    32'(m_valid));
    check({tag, ".pending"},  32'(pending),  32'(pend_value()));
    check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_lines = 8'h00;
    clr      = 1'b0;
    ready    = 1'b1;
    model_reset();
    #1;
    check_model("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;

    // 1) idle after reset
    for (int i = 0; i < 3; i++) begin
      step("idle");
      check("idle_valid", 32'(valid), 32'd0);
      check("idle_pending", 32'(pending), 32'd0);
      check("idle_out", 32'(out), 32'd0);
    end

    // 2) single pulse on bit 5
    in_lines = 8'h20;
    step("bit5_capture");
    check("bit5_pending", 32'(pending), 32'h20);
    in_lines = 8'h00;
    step("bit5_offer");
    check("bit5_valid", 32'(valid), 32'd1);
    check("bit5_out", 32'(out), 32'd5);
    step("bit5_accept");
    check("bit5_done", 32'(valid), 32'd0);

    // 3) simultaneous events 0, 4, 7 issue in ascending order
    in_lines = 8'h91;
    step("multi_capture");
    check("multi_pend0", 32'(pending), 32'h91);
    in_lines = 8'h00;
    step("multi_0");
    check("multi_out0", 32'(out), 32'd0);
    check("multi_pend1", 32'(pending), 32'h90);
    step("multi_4");
    check("multi_out4", 32'(out), 32'd4);
    check("multi_pend2", 32'(pending), 32'h80);
    step("multi_7");
    check("multi_out7", 32'(out), 32'd7);
    check("multi_pend3", 32'(pending), 32'h00);
    step("multi_drain");
    check("multi_idle", 32'(valid), 32'd0);

    // 4) overflow on a twice-pending bit under back-pressure
    ready    = 1'b0;
    in_lines = 8'h01;
    step("ovf_seed");
    in_lines = 8'h00;
    step("ovf_held");
    check("ovf_held_valid", 32'(valid), 32'd1);
    in_lines = 8'h08;
    step("ovf_first");
    check("ovf_first_flag", 32'(overflow), 32'd0);
    in_lines = 8'h00;
    step("ovf_gap");
    in_lines = 8'h08;
    step("ovf_second");
    check("ovf_second_flag", 32'(overflow), 32'd1);
    check("ovf_second_pend", 32'(pending), 32'h08);
    in_lines = 8'h00;
    step("ovf_after");
    check("ovf_pulse_end", 32'(overflow), 32'd0);
    ready = 1'b1;
    step("ovf_issue");
    check("ovf_code3", 32'(out), 32'd3);
    step("ovf_only_one");
    check("ovf_single_issue", 32'(valid), 32'd0);

    // 5) clear beats a same-cycle event
    ready    = 1'b0;
    in_lines = 8'h01;
    step("clr_seed");
    in_lines = 8'h00;
    step("clr_held");
    in_lines = 8'h0C;
    step("clr_pend");
    check("clr_pend_0c", 32'(pending), 32'h0C);
    in_lines = 8'h02;
    clr      = 1'b1;
    step("clr_apply");
    check("clr_pending", 32'(pending), 32'd0);
    check("clr_valid", 32'(valid), 32'd0);
    check("clr_overflow", 32'(overflow), 32'd0);
    clr = 1'b0;
    step("clr_after");
    in_lines = 8'h00;
    ready    = 1'b1;

    // 6) async reset mid-transfer, then high line at release counts as an edge
    ready    = 1'b0;
    in_lines = 8'h40;
    step("rst_seed");
    in_lines = 8'h00;
    step("rst_held");
    check("rst_out6", 32'(out), 32'd6);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_async_out", 32'(out), 32'd0);
    check("rst_async_valid", 32'(valid), 32'd0);
    check("rst_async_pending", 32'(pending), 32'd0);
    @(negedge clk);
    in_lines = 8'h04;
    ready    = 1'b1;
    rst_n    = 1'b1;
    step("rel_edge");
    check("rel_pending", 32'(pending), 32'h04);
    in_lines = 8'h00;
    step("rel_issue");
    check("rel_out2", 32'(out), 32'd2);

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      in_lines = ($urandom_range(0, 2) == 0) ? 8'($urandom) : in_lines;
      ready    = ($urandom_range(0, 3) != 0);
      clr      = ($urandom_range(0, 31) == 0);
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
